// File: rtl/match_scan_fsm.sv
// Sequential match detector: snapshots the board on start, scans one row per cycle then
// one column per cycle, and reports the clear mask and its popcount with busy/done.
module match_scan_fsm #(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int COLOR_W = 3,
   parameter int MIN_RUN = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [ROWS*COLS*COLOR_W-1:0]   board_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [ROWS*COLS-1:0]           clear_mask_o,
   output logic [$clog2(ROWS*COLS+1)-1:0] match_count_o,
   output logic                           match_found_o
);

   localparam int CELLS = ROWS * COLS;
   localparam int LMAX  = (ROWS > COLS) ? ROWS : COLS;
   localparam int IDX_W = $clog2(LMAX);
   localparam int CNT_W = $clog2(CELLS + 1);

   typedef enum logic [1:0] {IDLE, ROW, COL, FIN} state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [CELLS*COLOR_W-1:0]     snap_q, snap_d;
   logic [CELLS-1:0]             mask_q, mask_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic                         found_q, found_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;

   logic [COLOR_W-1:0]           lineCells [LMAX];
   logic [LMAX-1:0]              lineMark;
   logic [CNT_W-1:0]             popCount;

   // Unused tail positions stay zero, so no window can extend past the line end.
   always_comb begin
      for (int p = 0; p < LMAX; p++) begin
         lineCells[p] = '0;
      end
      if (state_q == COL) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (idx_q == IDX_W'(c)) begin
                  lineCells[r] = snap_q[(r*COLS+c)*COLOR_W +: COLOR_W];
               end
            end
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (idx_q == IDX_W'(r)) begin
                  lineCells[c] = snap_q[(r*COLS+c)*COLOR_W +: COLOR_W];
               end
            end
         end
      end
   end

   always_comb begin
      logic winOk;
      lineMark = '0;
      winOk    = 1'b0;
      for (int s = 0; s <= LMAX - MIN_RUN; s++) begin
         winOk = (lineCells[s] != '0);
         for (int k = 1; k < MIN_RUN; k++) begin
            if (lineCells[s+k] != lineCells[s]) begin
               winOk = 1'b0;
            end
         end
         if (winOk) begin
            for (int k = 0; k < MIN_RUN; k++) begin
               lineMark[s+k] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      popCount = '0;
      for (int i = 0; i < CELLS; i++) begin
         popCount = popCount + CNT_W'(mask_q[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      mask_d  = mask_q;
      count_d = count_q;
      found_d = found_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               snap_d  = board_i;
               mask_d  = '0;
               count_d = '0;
               found_d = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ROW;
            end
         end
         ROW: begin
            for (int r = 0; r < ROWS; r++) begin
               for (int c = 0; c < COLS; c++) begin
                  if (idx_q == IDX_W'(r)) begin
                     mask_d[r*COLS+c] = mask_q[r*COLS+c] | lineMark[c];
                  end
               end
            end
            if (idx_q == IDX_W'(ROWS-1)) begin
               idx_d   = '0;
               state_d = COL;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         COL: begin
            for (int r = 0; r < ROWS; r++) begin
               for (int c = 0; c < COLS; c++) begin
                  if (idx_q == IDX_W'(c)) begin
                     mask_d[r*COLS+c] = mask_q[r*COLS+c] | lineMark[r];
                  end
               end
            end
            if (idx_q == IDX_W'(COLS-1)) begin
               idx_d   = '0;
               state_d = FIN;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         FIN: begin
            count_d = popCount;
            found_d = (popCount != '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         snap_q  <= '0;
         mask_q  <= '0;
         count_q <= '0;
         found_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         mask_q  <= mask_d;
         count_q <= count_d;
         found_q <= found_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign clear_mask_o  = mask_q;
   assign match_count_o = count_q;
   assign match_found_o = found_q;

endmodule

// File: tb/tb_match_scan_fsm.sv
// Scoreboard bench for match_scan_fsm: an 8x8/MIN_RUN=3 instance and a 5x6/MIN_RUN=4 instance,
// with directed boards, handshake corner cases and an asynchronous reset mid-scan.
module tb_match_scan_fsm;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic        start8 = 1'b0;
   logic [191:0] board8 = '0;
   logic        busy8, done8, found8;
   logic [63:0] mask8;
   logic [6:0]  count8;

   logic        start56 = 1'b0;
   logic [89:0] board56 = '0;
   logic        busy56, done56, found56;
   logic [29:0] mask56;
   logic [4:0]  count56;

   int cyc        = 0;
   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      logic [63:0] mask;
      int          count;
      int          doneCyc;
   } exp_t;

   exp_t q8[$];
   exp_t q56[$];
   exp_t e8, e56;

   match_scan_fsm #(.ROWS(8), .COLS(8), .COLOR_W(3), .MIN_RUN(3)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .board_i(board8),
      .busy_o(busy8), .done_o(done8), .clear_mask_o(mask8),
      .match_count_o(count8), .match_found_o(found8)
   );

   match_scan_fsm #(.ROWS(5), .COLS(6), .COLOR_W(3), .MIN_RUN(4)) dut56 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start56), .board_i(board56),
      .busy_o(busy56), .done_o(done56), .clear_mask_o(mask56),
      .match_count_o(count56), .match_found_o(found56)
   );

   always #5 clk = ~clk;

   // Edge counter: after the edge that samples start it holds N; done must be seen with N+latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitors pop one expectation per done pulse; a done with nothing pending is itself a failure.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpectedDone8: done pulsed at cycle %0d with no scan pending", cyc);
         end else begin
            e8 = q8.pop_front();
            checkOutput("mask8",    64'(mask8),  e8.mask);
            checkOutput("count8",   64'(count8), 64'(e8.count));
            checkOutput("found8",   64'(found8), 64'(e8.count != 0));
            checkOutput("latency8", 64'(cyc),    64'(e8.doneCyc));
            checkOutput("busyAtDone8", 64'(busy8), 64'(0));
         end
      end
   end

   always @(negedge clk) begin
      if (done56 === 1'b1) begin
         if (q56.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpectedDone56: done pulsed at cycle %0d with no scan pending", cyc);
         end else begin
            e56 = q56.pop_front();
            checkOutput("mask56",    64'(mask56),  e56.mask);
            checkOutput("count56",   64'(count56), 64'(e56.count));
            checkOutput("found56",   64'(found56), 64'(e56.count != 0));
            checkOutput("latency56", 64'(cyc),     64'(e56.doneCyc));
         end
      end
   end

   function automatic logic [191:0] put8(input logic [191:0] b, input int r, input int c, input logic [2:0] col);
      logic [191:0] t;
      t = b;
      t[(r*8+c)*3 +: 3] = col;
      return t;
   endfunction

   function automatic logic [89:0] put56(input logic [89:0] b, input int r, input int c, input logic [2:0] col);
      logic [89:0] t;
      t = b;
      t[(r*6+c)*3 +: 3] = col;
      return t;
   endfunction

   task automatic applyStimulus(input logic [191:0] b, input logic [63:0] m, input int n);
      exp_t e;
      @(negedge clk);
      board8 = b;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8    = 1'b0;
      e.mask    = m;
      e.count   = n;
      e.doneCyc = cyc + 17;
      q8.push_back(e);
   endtask

   task automatic applyStimulusSmall(input logic [89:0] b, input logic [63:0] m, input int n);
      exp_t e;
      @(negedge clk);
      board56 = b;
      start56 = 1'b1;
      @(posedge clk);
      #1;
      start56   = 1'b0;
      e.mask    = m;
      e.count   = n;
      e.doneCyc = cyc + 12;
      q56.push_back(e);
   endtask

   task automatic waitDrain(input int sel);
      for (int i = 0; i < 40; i++) begin
         if ((sel == 0) ? (q8.size() == 0) : (q56.size() == 0)) break;
         @(negedge clk);
      end
      if ((sel == 0) ? (q8.size() != 0) : (q56.size() != 0)) begin
         checkCount++;
         $display("[TB] FAIL doneTimeout%0d: no done within 40 cycles", sel);
         if (sel == 0) q8.delete();
         else q56.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [191:0] bRow, bCross, bCol, bEmpty, bWrap, bPairs;
      logic [89:0]  bSmall3, bSmall4;
      exp_t         eTmp;

      bRow = '0;
      for (int c = 2; c <= 4; c++) bRow = put8(bRow, 3, c, 3'd5);

      bCross = '0;
      for (int c = 1; c <= 3; c++) bCross = put8(bCross, 4, c, 3'd2);
      for (int r = 3; r <= 5; r++) bCross = put8(bCross, r, 2, 3'd2);

      bCol = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 7; c++) bCol = put8(bCol, r, c, ((r + c) % 2 != 0) ? 3'd2 : 3'd1);
         bCol = put8(bCol, r, 7, 3'd7);
      end

      bEmpty = '0;

      bWrap = '0;
      bWrap = put8(bWrap, 0, 6, 3'd3);
      bWrap = put8(bWrap, 0, 7, 3'd3);
      bWrap = put8(bWrap, 1, 0, 3'd3);

      bPairs = '0;
      bPairs = put8(bPairs, 2, 0, 3'd4);
      bPairs = put8(bPairs, 2, 1, 3'd4);
      bPairs = put8(bPairs, 2, 3, 3'd5);
      bPairs = put8(bPairs, 2, 4, 3'd5);
      bPairs = put8(bPairs, 0, 5, 3'd6);
      bPairs = put8(bPairs, 1, 5, 3'd6);

      bSmall3 = '0;
      for (int c = 1; c <= 3; c++) bSmall3 = put56(bSmall3, 1, c, 3'd5);
      bSmall4 = '0;
      for (int c = 0; c <= 3; c++) bSmall4 = put56(bSmall4, 2, c, 3'd4);

      #1 rst_n = 1'b0;
      #2;
      checkOutput("resetBusy8",  64'(busy8),  64'(0));
      checkOutput("resetDone8",  64'(done8),  64'(0));
      checkOutput("resetMask8",  64'(mask8),  64'(0));
      checkOutput("resetCount8", 64'(count8), 64'(0));
      checkOutput("resetFound8", 64'(found8), 64'(0));
      checkOutput("resetBusy56", 64'(busy56), 64'(0));
      checkOutput("resetMask56", 64'(mask56), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic matches");
      applyStimulus(bRow, 64'h0000_0000_1C00_0000, 3);
      waitDrain(0);
      applyStimulus(bCross, 64'h0000_040E_0400_0000, 5);
      waitDrain(0);
      applyStimulus(bCol, 64'h8080_8080_8080_8080, 8);
      waitDrain(0);

      $display("[TB] negative boards");
      applyStimulus(bEmpty, 64'h0, 0);
      waitDrain(0);
      applyStimulus(bWrap, 64'h0, 0);
      waitDrain(0);
      applyStimulus(bPairs, 64'h0, 0);
      waitDrain(0);

      $display("[TB] start while busy");
      applyStimulus(bRow, 64'h0000_0000_1C00_0000, 3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("busyMidScan", 64'(busy8), 64'(1));
      start8 = 1'b1;
      board8 = bCross;
      @(posedge clk);
      #1 start8 = 1'b0;
      waitDrain(0);

      $display("[TB] start in done cycle");
      applyStimulus(bCol, 64'h8080_8080_8080_8080, 8);
      repeat (17) @(posedge clk);
      #1;
      checkOutput("doneBeforeRestart", 64'(done8), 64'(1));
      start8 = 1'b1;
      board8 = bCross;
      @(posedge clk);
      #1;
      start8       = 1'b0;
      eTmp.mask    = 64'h0000_040E_0400_0000;
      eTmp.count   = 5;
      eTmp.doneCyc = cyc + 17;
      q8.push_back(eTmp);
      checkOutput("busyAfterRestart", 64'(busy8), 64'(1));
      checkOutput("doneAfterRestart", 64'(done8), 64'(0));
      waitDrain(0);

      $display("[TB] reset during column scan");
      applyStimulus(bCross, 64'h0000_040E_0400_0000, 5);
      repeat (11) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abortBusy",  64'(busy8),  64'(0));
      checkOutput("abortDone",  64'(done8),  64'(0));
      checkOutput("abortMask",  64'(mask8),  64'(0));
      checkOutput("abortCount", 64'(count8), 64'(0));
      checkOutput("abortFound", 64'(found8), 64'(0));
      q8.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      checkOutput("idleAfterAbort", 64'(busy8), 64'(0));
      applyStimulus(bRow, 64'h0000_0000_1C00_0000, 3);
      waitDrain(0);

      $display("[TB] 5x6 instance, MIN_RUN=4");
      applyStimulusSmall(bSmall3, 64'h0, 0);
      waitDrain(1);
      applyStimulusSmall(bSmall4, 64'h0000_0000_0000_F000, 4);
      waitDrain(1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
